// File: rtl/avl_bus_type.sv
// Shared widths, master-ID type and command payload for the Avalon-style arbiter slice.
package avl_bus_type;

    localparam int unsigned AVL_ADDR_W     = 32;
    localparam int unsigned AVL_DATA_W     = 32;
    localparam int unsigned AVL_BE_W       = AVL_DATA_W / 8;
    localparam int unsigned MASTER_NUM_MAX = 16;
    localparam int unsigned MID_W          = $clog2(MASTER_NUM_MAX);

    typedef logic [MID_W-1:0] mid_t;

    typedef struct packed {
        logic [AVL_ADDR_W-1:0] address;
        logic [AVL_BE_W-1:0]   byte_en;
        logic [AVL_DATA_W-1:0] write_data;
        logic                  read;
        logic                  write;
    } avl_cmd_t;

    // Next master index after id, wrapping at num.
    function automatic mid_t mid_wrap_inc(input mid_t id, input int unsigned num);
        int unsigned nxt;
        nxt = 32'(id) + 32'd1;
        return (nxt >= num) ? '0 : mid_t'(nxt);
    endfunction

endpackage

// File: rtl/i_avl_bus.sv
// Avalon-style command/response bus; master drives commands, slave returns read data.
interface i_avl_bus;
    import avl_bus_type::*;

    logic [AVL_ADDR_W-1:0] address;
    logic [AVL_BE_W-1:0]   byte_en;
    logic                  read;
    logic                  write;
    logic [AVL_DATA_W-1:0] write_data;
    logic                  request_ready;
    logic [AVL_DATA_W-1:0] read_data;
    logic                  read_data_valid;
    logic                  resp_ready;

    modport master (
        output address, byte_en, read, write, write_data, resp_ready,
        input  request_ready, read_data, read_data_valid
    );

    modport slave (
        input  address, byte_en, read, write, write_data, resp_ready,
        output request_ready, read_data, read_data_valid
    );

endinterface

// File: rtl/avl_id_fifo.sv
// Synchronous FIFO of master IDs for outstanding reads; DEPTH must be a power of two.
module avl_id_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/avl_bus_rr_arbiter.sv
// N-to-1 Avalon-style arbiter with in-order read response routing by ID FIFO.
// Define AVL_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module avl_bus_rr_arbiter
    import avl_bus_type::*;
#(
    parameter int unsigned MASTER_NUM    = 8,
    parameter int unsigned RD_FIFO_DEPTH = 8
) (
    input  logic     clk,
    input  logic     rest,
    i_avl_bus.slave  avl_in [MASTER_NUM-1:0],
    i_avl_bus.master avl_out,
    output logic     err_unexp_resp
);

    logic [MASTER_NUM-1:0] req_rd;
    logic [MASTER_NUM-1:0] req_wr;
    logic [MASTER_NUM-1:0] rsp_rdy;
    logic [MASTER_NUM-1:0] elig;
    logic [MASTER_NUM-1:0] gnt_oh;
    logic [MASTER_NUM-1:0] head_oh;
    avl_cmd_t              cmd [MASTER_NUM];
    avl_cmd_t              out_cmd;
    mid_t                  gnt_idx;
    mid_t                  head_id;
    logic                  gnt_vld;
    logic                  cmd_rdy_c;
    logic                  hs;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  head_rsp_rdy;

    // Per-port unpack and response/ready fan-out.
    for (genvar i = 0; i < MASTER_NUM; i++) begin : g_port
        assign req_rd[i]  = avl_in[i].read;
        assign req_wr[i]  = avl_in[i].write;
        assign rsp_rdy[i] = avl_in[i].resp_ready;
        assign cmd[i]     = '{address:    avl_in[i].address,
                              byte_en:    avl_in[i].byte_en,
                              write_data: avl_in[i].write_data,
                              read:       avl_in[i].read,
                              write:      avl_in[i].write};

        // Reads drop out of arbitration while the ID FIFO is full so writes behind them still win.
        assign elig[i]    = rest && (req_wr[i] || (req_rd[i] && !fifo_full));
        assign gnt_oh[i]  = gnt_vld && (gnt_idx == mid_t'(i));
        assign head_oh[i] = !fifo_empty && (head_id == mid_t'(i));

        assign avl_in[i].request_ready   = gnt_oh[i] && cmd_rdy_c;
        assign avl_in[i].read_data_valid = head_oh[i] && avl_out.read_data_valid;
        assign avl_in[i].read_data       = head_oh[i] ? avl_out.read_data : '0;
    end

`ifdef AVL_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = int'(MASTER_NUM) - 1; i >= 0; i--) begin
            if (elig[i]) begin
                gnt_vld = 1'b1;
                gnt_idx = mid_t'(i);
            end
        end
    end
`else
    mid_t rr_ptr;
    mid_t lo_idx;
    mid_t hi_idx;
    logic lo_vld;
    logic hi_vld;

    // Lowest eligible at/above the pointer, else lowest eligible overall (wrap).
    always_comb begin
        lo_vld = 1'b0;
        hi_vld = 1'b0;
        lo_idx = '0;
        hi_idx = '0;
        for (int i = int'(MASTER_NUM) - 1; i >= 0; i--) begin
            if (elig[i]) begin
                lo_vld = 1'b1;
                lo_idx = mid_t'(i);
            end
            if (elig[i] && (mid_t'(i) >= rr_ptr)) begin
                hi_vld = 1'b1;
                hi_idx = mid_t'(i);
            end
        end
        gnt_vld = lo_vld;
        gnt_idx = hi_vld ? hi_idx : lo_idx;
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            rr_ptr <= '0;
        end else if (hs) begin
            rr_ptr <= mid_wrap_inc(gnt_idx, MASTER_NUM);
        end
    end
`endif

    // Granted command and head resp_ready selection.
    always_comb begin
        out_cmd      = '0;
        head_rsp_rdy = 1'b0;
        for (int i = 0; i < int'(MASTER_NUM); i++) begin
            if (gnt_oh[i]) begin
                out_cmd = cmd[i];
            end
            if (head_oh[i]) begin
                head_rsp_rdy = rsp_rdy[i];
            end
        end
    end

    assign cmd_rdy_c = avl_out.request_ready && !(out_cmd.read && fifo_full);
    assign hs        = gnt_vld && cmd_rdy_c;
    assign push      = hs && out_cmd.read;
    assign pop       = avl_out.read_data_valid && avl_out.resp_ready && !fifo_empty;

    assign avl_out.address    = out_cmd.address;
    assign avl_out.byte_en    = out_cmd.byte_en;
    assign avl_out.write_data = out_cmd.write_data;
    assign avl_out.read       = out_cmd.read;
    assign avl_out.write      = out_cmd.write;
    // With nothing outstanding the slave is drained rather than stalled.
    assign avl_out.resp_ready = fifo_empty ? 1'b1 : head_rsp_rdy;

    avl_id_fifo #(
        .WIDTH (MID_W),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_id_fifo (
        .clk       (clk),
        .rst_n     (rest),
        .push      (push),
        .push_data (gnt_idx),
        .pop       (pop),
        .pop_data  (head_id),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            err_unexp_resp <= 1'b0;
        end else if (avl_out.read_data_valid && fifo_empty) begin
            err_unexp_resp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_avl_bus_rr_arbiter.sv
// Bench for avl_bus_rr_arbiter: directed scenarios plus randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_avl_bus_rr_arbiter;
    import avl_bus_type::*;

    localparam int unsigned N     = 8;
    localparam int unsigned DEPTH = 4;

    logic clk  = 1'b0;
    logic rest = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]          m_rd, m_wr, m_resp, m_rr, m_rdv;
    logic [AVL_ADDR_W-1:0] m_addr  [N];
    logic [AVL_BE_W-1:0]   m_be    [N];
    logic [AVL_DATA_W-1:0] m_wd    [N];
    logic [AVL_DATA_W-1:0] m_rdata [N];

    logic [AVL_ADDR_W-1:0] s_addr;
    logic [AVL_BE_W-1:0]   s_be;
    logic [AVL_DATA_W-1:0] s_wd, s_rdata;
    logic                  s_rd, s_wr, s_resp, s_rr, s_rdv;
    logic                  err;

    i_avl_bus m_if [N-1:0] ();
    i_avl_bus s_if ();

    for (genvar g = 0; g < N; g++) begin : g_m
        assign m_if[g].address    = m_addr[g];
        assign m_if[g].byte_en    = m_be[g];
        assign m_if[g].write_data = m_wd[g];
        assign m_if[g].read       = m_rd[g];
        assign m_if[g].write      = m_wr[g];
        assign m_if[g].resp_ready = m_resp[g];
        assign m_rr[g]            = m_if[g].request_ready;
        assign m_rdv[g]           = m_if[g].read_data_valid;
        assign m_rdata[g]         = m_if[g].read_data;
    end

    assign s_addr                 = s_if.address;
    assign s_be                   = s_if.byte_en;
    assign s_wd                   = s_if.write_data;
    assign s_rd                   = s_if.read;
    assign s_wr                   = s_if.write;
    assign s_resp                 = s_if.resp_ready;
    assign s_if.request_ready     = s_rr;
    assign s_if.read_data_valid   = s_rdv;
    assign s_if.read_data         = s_rdata;

    avl_bus_rr_arbiter #(
        .MASTER_NUM    (N),
        .RD_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rest           (rest),
        .avl_in         (m_if),
        .avl_out        (s_if),
        .err_unexp_resp (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0h required=%0h t=%0t", name, idx, act, exp, $time);
        end
    endtask

    // Reference model: rr pointer, queue of outstanding read owners, sticky error.
    int mdl_ptr = 0;
    int mdl_q[$];
    bit mdl_err = 1'b0;

    always @(negedge clk) begin : p_cmp
        int g;
        int head;
        logic [N-1:0] elig;
        if (!rest) begin
            mdl_ptr = 0;
            mdl_q.delete();
            mdl_err = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            elig[i] = rest && (m_wr[i] || (m_rd[i] && (mdl_q.size() < DEPTH)));
        end
        g = -1;
`ifdef AVL_ARB_FIXED_PRIO_EN
        for (int i = N - 1; i >= 0; i--) if (elig[i]) g = i;
`else
        for (int k = 0; k < N; k++) begin
            if (g < 0 && elig[(mdl_ptr + k) % N]) g = (mdl_ptr + k) % N;
        end
`endif
        head = (mdl_q.size() > 0) ? mdl_q[0] : -1;

        chk("out_read",  0, s_rd,   (g >= 0) ? m_rd[g]   : 1'b0);
        chk("out_write", 0, s_wr,   (g >= 0) ? m_wr[g]   : 1'b0);
        chk("out_addr",  0, s_addr, (g >= 0) ? m_addr[g] : '0);
        chk("out_be",    0, s_be,   (g >= 0) ? m_be[g]   : '0);
        chk("out_wdata", 0, s_wd,   (g >= 0) ? m_wd[g]   : '0);
        for (int i = 0; i < N; i++) begin
            chk("req_ready", i, m_rr[i],    (i == g) && s_rr);
            chk("rd_valid",  i, m_rdv[i],   (i == head) && s_rdv);
            chk("rd_data",   i, m_rdata[i], (i == head) ? s_rdata : '0);
        end
        chk("out_resp_ready", 0, s_resp, (head >= 0) ? m_resp[head] : 1'b1);
        chk("err_unexp", 0, err, mdl_err);

        if (rest) begin
            if (s_rdv && head < 0) mdl_err = 1'b1;
            if (head >= 0 && s_rdv && m_resp[head]) void'(mdl_q.pop_front());
            if (g >= 0 && s_rr) begin
                if (m_rd[g]) mdl_q.push_back(g);
                mdl_ptr = (g + 1) % N;
            end
        end
    end

    int obs_hs, obs_rsp, obs_nrsp;
    logic [AVL_DATA_W-1:0] obs_rdata;

    task automatic observe();
        @(negedge clk);
        obs_hs = -1; obs_rsp = -1; obs_nrsp = 0; obs_rdata = '0;
        for (int i = 0; i < N; i++) begin
            if ((m_rd[i] || m_wr[i]) && m_rr[i]) obs_hs = i;
            if (m_rdv[i]) begin
                obs_rsp = i; obs_nrsp++; obs_rdata = m_rdata[i];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input int m);
        int guard = 0;
        bit got = 1'b0;
        while (!got && guard < 20) begin
            observe(); tick();
            if (obs_hs == m) got = 1'b1;
            guard++;
        end
        m_rd[m] = 1'b0;
        m_wr[m] = 1'b0;
        chk("accept_wait", m, got, 1'b1);
    endtask

    initial begin
        int exp_a [6] = '{0, 3, 5, 0, 3, 5};
        int exp_b [6] = '{1, 2, 1, 2, 1, 2};
        int seq_c [3] = '{2, 6, 2};
        logic [AVL_DATA_W-1:0] dat_c [3] = '{32'hA, 32'hB, 32'hC};
        int left [N];
        int n_acc, n_rsp, outst, guard;
        bit wr7_ok;

        m_rd = '0; m_wr = '0; m_resp = '1;
        s_rr = 1'b0; s_rdv = 1'b0; s_rdata = '0;
        for (int i = 0; i < N; i++) begin
            m_addr[i] = 32'h1000 * i; m_be[i] = 4'hF; m_wd[i] = 32'hD000 + i; left[i] = 0;
        end
        #1 rest = 1'b0;

        // Reset holds everything quiet even with traffic present.
        m_wr[0] = 1'b1; s_rr = 1'b1; s_rdv = 1'b1;
        repeat (3) begin
            observe();
            chk("rst_req_ready", 0, m_rr, '0);
            chk("rst_rd_valid", 0, m_rdv, '0);
            chk("rst_err", 0, err, 1'b0);
            tick();
        end
        m_wr[0] = 1'b0; s_rdv = 1'b0;
        rest = 1'b1;
        tick();

        // Round-robin among continuous writers 0,3,5.
        m_wr[0] = 1'b1; m_wr[3] = 1'b1; m_wr[5] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            observe();
            chk("rr_grant", k, obs_hs, exp_a[k]);
            tick();
            if (obs_hs >= 0) m_addr[obs_hs] = $urandom;
        end
        m_wr = '0;

        // ID FIFO fills at 4 reads; write from master 7 still gets through.
        left[1] = 3; left[2] = 3; m_rd[1] = 1'b1; m_rd[2] = 1'b1;
        n_acc = 0; wr7_ok = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c == 6) m_wr[7] = 1'b1;
            observe();
            if (c >= 4) begin
                chk("full_block_m1", c, m_rr[1], 1'b0);
                chk("full_block_m2", c, m_rr[2], 1'b0);
            end
            tick();
            if (obs_hs == 7) begin wr7_ok = 1'b1; m_wr[7] = 1'b0; end
            else if (obs_hs >= 0) begin
                if (n_acc < 6) chk("fill_order", n_acc, obs_hs, exp_b[n_acc]);
                n_acc++; left[obs_hs]--;
                if (left[obs_hs] == 0) m_rd[obs_hs] = 1'b0;
            end
        end
        chk("full_accepts", 0, n_acc, 4);
        chk("full_write_m7", 0, wr7_ok, 1'b1);

        // Drain; remaining reads re-enter as space frees.
        outst = n_acc; n_rsp = 0; guard = 0;
        while (n_rsp < 6 && guard < 40) begin
            s_rdv = (outst > 0); s_rdata = 32'h100 + n_rsp;
            observe();
            tick();
            if (obs_hs >= 0) begin
                outst++; left[obs_hs]--;
                if (left[obs_hs] == 0) m_rd[obs_hs] = 1'b0;
            end
            if (obs_rsp >= 0) begin
                chk("drain_order", n_rsp, obs_rsp, exp_b[n_rsp]);
                chk("drain_data", n_rsp, obs_rdata, 32'h100 + n_rsp);
                n_rsp++; outst--;
            end
            guard++;
        end
        chk("drain_count", 0, n_rsp, 6);
        s_rdv = 1'b0; m_rd = '0;

        // In-order routing m2, m6, m2.
        for (int k = 0; k < 3; k++) begin
            m_rd[seq_c[k]] = 1'b1;
            wait_accept(seq_c[k]);
        end
        for (int k = 0; k < 3; k++) begin
            s_rdv = 1'b1; s_rdata = dat_c[k];
            observe();
            chk("route_master", k, obs_rsp, seq_c[k]);
            chk("route_data", k, obs_rdata, dat_c[k]);
            chk("route_single", k, obs_nrsp, 1);
            tick();
        end
        s_rdv = 1'b0;

        // Head stalls resp_ready for 3 cycles.
        m_rd[4] = 1'b1;
        wait_accept(4);
        m_resp = '1; m_resp[4] = 1'b0; s_rdv = 1'b1; s_rdata = 32'h55;
        for (int k = 0; k < 3; k++) begin
            observe();
            chk("stall_resp_ready", k, s_resp, 1'b0);
            chk("stall_rd_valid", k, m_rdv[4], 1'b1);
            tick();
        end
        m_resp[4] = 1'b1;
        observe(); chk("release_resp_ready", 0, s_resp, 1'b1); tick();
        m_resp[4] = 1'b0; s_rdv = 1'b0;
        observe(); chk("popped_resp_ready", 0, s_resp, 1'b1); tick();
        m_resp = '1;

        // Unexpected response is sticky until reset.
        s_rdv = 1'b1; s_rdata = 32'hBAD;
        observe(); chk("unexp_before", 0, err, 1'b0); tick();
        s_rdv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            observe(); chk("unexp_sticky", k, err, 1'b1); tick();
        end
        rest = 1'b0;
        observe(); chk("unexp_cleared", 0, err, 1'b0); tick();
        rest = 1'b1;
        tick();

        // Reset discards an outstanding read; its late response is unexpected.
        m_rd[3] = 1'b1;
        wait_accept(3);
        rest = 1'b0; tick(); rest = 1'b1;
        s_rdv = 1'b1;
        observe(); chk("late_rsp_unrouted", 0, m_rdv[3], 1'b0); tick();
        s_rdv = 1'b0;
        observe(); chk("late_rsp_err", 0, err, 1'b1); tick();
        rest = 1'b0; tick(); rest = 1'b1; tick();

`ifdef AVL_ARB_FIXED_PRIO_EN
        m_wr[2] = 1'b1; m_wr[4] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            observe(); chk("fixed_grant", k, obs_hs, 2); tick();
        end
        m_wr = '0;
        tick();
`endif

        // Randomized traffic, one mid-run reset.
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) rest = 1'b0;
            if (c == 702) rest = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (!m_rd[i] && !m_wr[i] && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 1) == 0) m_rd[i] = 1'b1; else m_wr[i] = 1'b1;
                    m_addr[i] = $urandom;
                    m_be[i]   = AVL_BE_W'($urandom);
                    m_wd[i]   = $urandom;
                end
                m_resp[i] = ($urandom_range(0, 3) != 0);
            end
            s_rr    = ($urandom_range(0, 3) != 0);
            s_rdv   = ($urandom_range(0, 3) == 0);
            s_rdata = $urandom;
            observe();
            tick();
            if (obs_hs >= 0) begin
                m_rd[obs_hs] = 1'b0;
                m_wr[obs_hs] = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
